// File: rtl/wb_spi_arbiter.sv
// Two-master Wishbone classic arbiter in front of a shared SPI peripheral bus.
// Round-robin on contention, ownership held for the whole cycle, and a
// per-owner bus timeout that answers with err and a one-cycle interrupt.
//
// state | meaning
// IDLE  | no owner, slave bus parked at zero
// OWN0  | master 0 owns the slave bus until it drops cyc
// OWN1  | master 1 owns the slave bus until it drops cyc
module wb_spi_arbiter #(
  parameter int unsigned TO_CYC = 255,
  parameter int unsigned AW     = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic          s_ack_i,
  input  logic [31:0]   s_dat_i,
  output logic [1:0]    grant_o,
  output logic          to_irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

  state_t      state, state_nxt;
  logic        last_owner;
  logic [15:0] to_cnt;
  logic        to_err;
  logic        req0, req1;
  logic        to_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Threshold reached on an unacknowledged strobe; an ack in the same cycle wins.
  assign to_hit = s_stb_o & ~s_ack_i & (to_cnt == TO_LAST);

  // Next-state: arbitrate only from IDLE, release when the owner drops cyc.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0:    if (!m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin memory; reset favours master 0 next.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) last_owner <= (state_nxt == OWN1);
    end
  end

  // Timeout counter and the one-cycle error flag it raises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state == IDLE || state_nxt == IDLE) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      to_err <= to_hit;
      if (s_ack_i || to_hit) to_cnt <= '0;
      else if (s_stb_o)      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Output steering: owner is wired through, everything else is held at zero.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = 2'b00;
    case (state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~to_err;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = to_err;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~to_err;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = to_err;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

  assign to_irq_o = to_err;

endmodule
